// File: rtl/vga_rect_pos_ctrl.sv
// rtl/vga_rect_pos_ctrl.sv - round-robin position arbiter with frame-synchronous commit
//
// Holds the on-screen rectangle position. Two requesters post (x,y) updates
// with a req/ack handshake. Arbitration is round-robin, and the accepted value
// is clamped so the rectangle stays on screen. That value goes into a shadow
// register. The shadow is copied to rect_x/rect_y only on frame_end, so a
// frame never shows a torn position.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   frame_end         1-cycle pulse at start of vertical blanking
//   req0/x0/y0, ack0  requester 0 (req held until ack; data stable while req)
//   req1/x1/y1, ack1  requester 1, same rules
//   rect_x, rect_y    committed rectangle top-left corner
//   pending           shadow holds an uncommitted update
//   clamped           sticky: an accepted update was clamped since last commit
module vga_rect_pos_ctrl #(
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int X_MAX  = 799,
    parameter int Y_MAX  = 599,
    parameter int RECT_W = 31,
    parameter int RECT_H = 31,
    parameter int DEF_X  = 385,
    parameter int DEF_Y  = 285
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_end,
    input  logic          req0,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    output logic          ack0,
    input  logic          req1,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic          ack1,
    output logic [XW-1:0] rect_x,
    output logic [YW-1:0] rect_y,
    output logic          pending,
    output logic          clamped
);

    // Largest top-left corner that keeps the whole rectangle in the active area.
    // Held one bit wider so that the compare cannot wrap.
    localparam logic [XW:0] X_LIM = (XW+1)'(X_MAX - RECT_W + 1);
    localparam logic [YW:0] Y_LIM = (YW+1)'(Y_MAX - RECT_H + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          winner, winner_nxt;
    logic          last_grant;
    logic          grant_fire;
    logic          commit;
    logic [XW-1:0] shadow_x;
    logic [YW-1:0] shadow_y;
    logic [XW-1:0] sel_x, wr_x;
    logic [YW-1:0] sel_y, wr_y;
    logic          x_over, y_over, clamp_now;

    // The winner's data is read during GRANT. The requester keeps it stable
    // until it has seen the ack.
    always_comb begin
        sel_x     = winner ? x1 : x0;
        sel_y     = winner ? y1 : y0;
        x_over    = {1'b0, sel_x} > X_LIM;
        y_over    = {1'b0, sel_y} > Y_LIM;
        wr_x      = x_over ? X_LIM[XW-1:0] : sel_x;
        wr_y      = y_over ? Y_LIM[YW-1:0] : sel_y;
        clamp_now = x_over | y_over;
        commit    = frame_end & pending;
    end

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        ack0       = 1'b0;
        ack1       = 1'b0;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nxt = GRANT;
                    // If both requesters are asking, the one not served last time wins.
                    if (req0 & req1) winner_nxt = ~last_grant;
                    else             winner_nxt = req1;
                end
            end
            GRANT: begin
                ack0       = ~winner;
                ack1       = winner;
                grant_fire = 1'b1;
                state_nxt  = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            shadow_x   <= XW'(DEF_X);
            shadow_y   <= YW'(DEF_Y);
            rect_x     <= XW'(DEF_X);
            rect_y     <= YW'(DEF_Y);
            pending    <= 1'b0;
            clamped    <= 1'b0;
        end else begin
            state  <= state_nxt;
            winner <= winner_nxt;
            // The commit reads the shadow before this cycle's grant writes it.
            if (commit) begin
                rect_x <= shadow_x;
                rect_y <= shadow_y;
            end
            if (grant_fire) begin
                shadow_x   <= wr_x;
                shadow_y   <= wr_y;
                last_grant <= winner;
                pending    <= 1'b1;
                // When the grant and the commit happen together, the flag
                // describes only the write that is still waiting.
                clamped    <= commit ? clamp_now : (clamped | clamp_now);
            end else if (commit) begin
                pending <= 1'b0;
                clamped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_pos_ctrl.sv
// tb/tb_vga_rect_pos_ctrl.sv - directed and randomized bench for vga_rect_pos_ctrl
module tb_vga_rect_pos_ctrl;

    localparam int LIM_X = 799 - 31 + 1;
    localparam int LIM_Y = 599 - 31 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_end = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic       ack0, ack1, pending, clamped;
    logic [9:0] rect_x, rect_y;

    int ncmp  = 0;
    int nfail = 0;
    bit hold  = 1'b0;

    // Reference model: what the display position, shadow and handshake should be
    int m_rx, m_ry, m_sx, m_sy, m_pend, m_clamp, m_last;
    int m_ack  = -1;   // requester whose ack is visible this cycle, -1 for none
    int m_busy = 0;    // cycles before the arbiter will look at requests again

    always #5 clk = ~clk;

    vga_rect_pos_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .req0      (req0),
        .x0        (x0),
        .y0        (y0),
        .ack0      (ack0),
        .req1      (req1),
        .x1        (x1),
        .y1        (y1),
        .ack1      (ack1),
        .rect_x    (rect_x),
        .rect_y    (rect_y),
        .pending   (pending),
        .clamped   (clamped)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step the model one clock using the current inputs. Then take the clock
    // edge and compare every output with the model 1 ns later.
    task automatic tick();
        int  sx, sy;
        bit  accept, commit, c;
        sx = 0; sy = 0; c = 1'b0;
        if (rst) begin
            m_rx = 385; m_ry = 285; m_sx = 385; m_sy = 285;
            m_pend = 0; m_clamp = 0; m_last = 1; m_ack = -1; m_busy = 0;
        end else begin
            accept = (m_ack >= 0);
            commit = frame_end && (m_pend != 0);
            if (accept) begin
                sx = (m_ack == 1) ? int'(x1) : int'(x0);
                sy = (m_ack == 1) ? int'(y1) : int'(y0);
                c  = (sx > LIM_X) || (sy > LIM_Y);
            end
            if (commit) begin
                m_rx = m_sx;
                m_ry = m_sy;
            end
            if (accept) begin
                m_sx    = (sx > LIM_X) ? LIM_X : sx;
                m_sy    = (sy > LIM_Y) ? LIM_Y : sy;
                m_last  = m_ack;
                m_pend  = 1;
                m_clamp = commit ? int'(c) : int'((m_clamp != 0) || c);
            end else if (commit) begin
                m_pend  = 0;
                m_clamp = 0;
            end
            if (m_ack >= 0) begin
                m_ack  = -1;
                m_busy = 1;
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (req0 && req1) begin
                m_ack = 1 - m_last;
            end else if (req0) begin
                m_ack = 0;
            end else if (req1) begin
                m_ack = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("ack0",    32'(ack0),    32'(m_ack == 0));
        chk("ack1",    32'(ack1),    32'(m_ack == 1));
        chk("rect_x",  32'(rect_x),  32'(m_rx));
        chk("rect_y",  32'(rect_y),  32'(m_ry));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("clamped", 32'(clamped), 32'(m_clamp));
        // A requester drops its request once it sees its ack
        if (!hold) begin
            if (m_ack == 0) req0 = 1'b0;
            if (m_ack == 1) req1 = 1'b0;
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rect_x", 32'(rect_x), 32'd385);
        chk("rst_rect_y", 32'(rect_y), 32'd285);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        rst = 1'b0;

        // Single write from requester 0
        req0 = 1'b1; x0 = 10'd100; y0 = 10'd200;
        tick();
        chk("single_ack0", 32'(ack0), 32'd1);
        tick();
        chk("single_pending", 32'(pending), 32'd1);
        chk("single_hold_x", 32'(rect_x), 32'd385);
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("single_rect_x", 32'(rect_x), 32'd100);
        chk("single_rect_y", 32'(rect_y), 32'd200);
        chk("single_pend0", 32'(pending), 32'd0);

        // Contention from a fresh reset: acks alternate every 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold = 1'b1;
        req0 = 1'b1; x0 = 10'd11; y0 = 10'd22;
        req1 = 1'b1; x1 = 10'd33; y1 = 10'd44;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("cont_ack0", 32'(ack0), 32'(i % 6 == 0));
            chk("cont_ack1", 32'(ack1), 32'(i % 6 == 3));
        end
        req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("cont_rect_x", 32'(rect_x), 32'd33);
        chk("cont_rect_y", 32'(rect_y), 32'd44);

        // Clamp at the right and bottom edges
        req1 = 1'b1; x1 = 10'd790; y1 = 10'd595;
        tick();
        chk("clamp_ack1", 32'(ack1), 32'd1);
        tick();
        chk("clamp_flag", 32'(clamped), 32'd1);
        tick();
        chk("clamp_flag_held", 32'(clamped), 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("clamp_rect_x", 32'(rect_x), 32'd769);
        chk("clamp_rect_y", 32'(rect_y), 32'd569);
        chk("clamp_cleared", 32'(clamped), 32'd0);

        // A grant in the same cycle as frame_end
        req0 = 1'b1; x0 = 10'd50; y0 = 10'd60;
        tick();
        tick();
        tick();
        req0 = 1'b1; x0 = 10'd10; y0 = 10'd20;
        tick();
        chk("coll_ack0", 32'(ack0), 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("coll_rect_x", 32'(rect_x), 32'd50);
        chk("coll_rect_y", 32'(rect_y), 32'd60);
        chk("coll_pending", 32'(pending), 32'd1);
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("coll_rect_x2", 32'(rect_x), 32'd10);
        chk("coll_rect_y2", 32'(rect_y), 32'd20);

        // Reset asserted in the ack cycle
        req0 = 1'b1; x0 = 10'd200; y0 = 10'd300;
        tick();
        chk("rstg_ack0", 32'(ack0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstg_rect_x", 32'(rect_x), 32'd385);
        chk("rstg_pending", 32'(pending), 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("rstg_nocommit_x", 32'(rect_x), 32'd385);
        chk("rstg_nocommit_y", 32'(rect_y), 32'd285);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            frame_end = ($urandom_range(0, 15) == 0);
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                x0   = 10'($urandom_range(0, 1023));
                y0   = 10'($urandom_range(0, 1023));
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                x1   = 10'($urandom_range(0, 1023));
                y1   = 10'($urandom_range(0, 1023));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
